// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI3 slave memory.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Byte lanes in one data word.
  function automatic int unsigned bytes_lanes(input int unsigned dw);
    return dw / 8;
  endfunction

  // log2 of the byte lanes: shift from byte address to word index.
  function automatic int unsigned lane_bits(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI3 next-beat address generator with burst legality check.
// Illegal WRAP lengths and the reserved burst encoding advance as INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  illegal_o
);

  localparam int unsigned LANE_BITS = lane_bits(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] bpb, aligned, incr, wrap_bytes, wrap_base;
  logic                  size_bad, burst_bad, wrap_len_bad;

  // Compute the incrementing and wrapping candidates, then pick by burst type.
  always_comb begin
    bpb          = ADDR_WIDTH'(1) << size_i;
    aligned      = addr_i & ~(bpb - ADDR_WIDTH'(1));
    incr         = aligned + bpb;
    wrap_bytes   = ADDR_WIDTH'({1'b0, len_i} + 9'd1) << size_i;
    wrap_base    = aligned & ~(wrap_bytes - ADDR_WIDTH'(1));
    size_bad     = int'(size_i) > int'(LANE_BITS);
    burst_bad    = (burst_i == 2'b11);
    wrap_len_bad = (burst_i == WRAP) &&
                   !((len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15));
    illegal_o    = size_bad || burst_bad || wrap_len_bad;
    next_addr_o  = incr;
    if (burst_i == FIXED)
      next_addr_o = addr_i;
    else if ((burst_i == WRAP) && !wrap_len_bad && (incr == wrap_base + wrap_bytes))
      next_addr_o = wrap_base;
  end

endmodule

// File: rtl/axi_slv_mem.sv
// AXI3 slave backed by a word-addressed memory; one outstanding write and
// one outstanding read, with independent write and read paths.
module axi_slv_mem
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [3:0]              awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [3:0]              wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [3:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [3:0]              arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [3:0]              rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned NB        = bytes_lanes(DATA_WIDTH);
  localparam int unsigned LANE_BITS = lane_bits(DATA_WIDTH);
  localparam int unsigned MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write path state
  wr_state_e             wst_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [3:0]            wid_q, bid_q;
  logic [1:0]            bresp_q, wburst_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wbeat_q;
  logic [2:0]            wsize_q;

  // Read path state
  rd_state_e             rst_q;
  logic                  arready_q, rvalid_q, rlast_q, rill_q;
  logic [3:0]            rid_q;
  logic [1:0]            rresp_q, rburst_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rbeat_q;
  logic [2:0]            rsize_q;

  // Address generators: fed by the request channel while idle so the
  // legality flag is known at the address handshake.
  logic                  w_idle, r_idle;
  logic [ADDR_WIDTH-1:0] wgen_next, rgen_next;
  logic                  wgen_ill, rgen_ill;

  assign w_idle = (wst_q == W_IDLE);
  assign r_idle = (rst_q == R_IDLE);

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wgen (
    .addr_i      (w_idle ? awaddr  : waddr_q),
    .len_i       (w_idle ? awlen   : wlen_q),
    .size_i      (w_idle ? awsize  : wsize_q),
    .burst_i     (w_idle ? awburst : wburst_q),
    .next_addr_o (wgen_next),
    .illegal_o   (wgen_ill)
  );

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rgen (
    .addr_i      (r_idle ? araddr  : raddr_q),
    .len_i       (r_idle ? arlen   : rlen_q),
    .size_i      (r_idle ? arsize  : rsize_q),
    .burst_i     (r_idle ? arburst : rburst_q),
    .next_addr_o (rgen_next),
    .illegal_o   (rgen_ill)
  );

  // Word indices and range checks for the current write beat and the beat
  // about to be loaded into the read data register.
  logic [ADDR_WIDTH-1:0] w_idx, r_idx;
  logic                  w_in_rng, r_in_rng, w_hs, mem_we, w_last_beat, werr_d;
  logic [DATA_WIDTH-1:0] r_word;

  assign w_idx       = waddr_q >> LANE_BITS;
  assign r_idx       = (r_idle ? araddr : rgen_next) >> LANE_BITS;
  assign w_in_rng    = w_idx < ADDR_WIDTH'(MEM_DEPTH);
  assign r_in_rng    = r_idx < ADDR_WIDTH'(MEM_DEPTH);
  assign r_word      = r_in_rng ? mem[r_idx[MEM_AW-1:0]] : '0;
  assign w_hs        = (wst_q == W_DATA) && wvalid && wready_q;
  assign mem_we      = w_hs && w_in_rng;
  assign w_last_beat = (wbeat_q == wlen_q);
  assign werr_d      = werr_q || (wid != wid_q) || (wlast != w_last_beat);

  // Byte-enabled memory write; contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    if (mem_we)
      for (int b = 0; b < int'(NB); b++)
        if (wstrb[b]) mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
  end

  // Write FSM: AW accept, W beats until awlen, then hold B until bready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wst_q)
        W_IDLE: if (awvalid && awready_q) begin
          wid_q     <= awid;
          waddr_q   <= awaddr;
          wlen_q    <= awlen;
          wsize_q   <= awsize;
          wburst_q  <= awburst;
          wbeat_q   <= '0;
          werr_q    <= wgen_ill;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wst_q     <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          waddr_q <= wgen_next;
          wbeat_q <= wbeat_q + 8'd1;
          werr_q  <= werr_d;
          if (w_last_beat) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bid_q    <= wid_q;
            bresp_q  <= werr_d ? SLVERR : OKAY;
            wst_q    <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wst_q     <= W_IDLE;
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: beat 0 loads at AR accept, each R handshake loads the next beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rill_q    <= 1'b0;
    end else begin
      case (rst_q)
        R_IDLE: if (arvalid && arready_q) begin
          rid_q     <= arid;
          raddr_q   <= araddr;
          rlen_q    <= arlen;
          rsize_q   <= arsize;
          rburst_q  <= arburst;
          rill_q    <= rgen_ill;
          rbeat_q   <= '0;
          rvalid_q  <= 1'b1;
          rlast_q   <= (arlen == 8'd0);
          rdata_q   <= r_word;
          rresp_q   <= (rgen_ill || !r_in_rng) ? SLVERR : OKAY;
          arready_q <= 1'b0;
          rst_q     <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rst_q     <= R_IDLE;
          end else begin
            raddr_q <= rgen_next;
            rbeat_q <= rbeat_q + 8'd1;
            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
            rdata_q <= r_word;
            rresp_q <= (rill_q || !r_in_rng) ? SLVERR : OKAY;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Randomized self-checking bench for axi_slv_mem against a word-array model.
module tb_axi_slv_mem;

  localparam int DEPTH = 1024;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [3:0]  awid = '0, wid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;

  axi_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int          n_chk = 0, n_err = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules: legality and the byte address of beat i.
  function automatic bit illegal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    longint bpb, total, al, base;
    bpb   = longint'(1) << size;
    total = (longint'(len) + 1) * bpb;
    al    = (longint'(a) / bpb) * bpb;
    if (i == 0 || burst == 2'b00) return a;
    if (burst == 2'b10 && !illegal(len, 3'd0, burst)) begin
      base = (longint'(a) / total) * total;
      return 32'(base + ((al - base) + longint'(i) * bpb) % total);
    end
    return 32'(al + longint'(i) * bpb);
  endfunction

  task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx < DEPTH)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // mode: 0 clean, 1 wrong wid on beat 0, 2 early/missing wlast, 3 no wlast
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input bit gaps, input int bdly);
    logic [1:0] exp_resp;
    int to;
    exp_resp = (illegal(len, size, burst) || mode != 0) ? 2'b10 : 2'b00;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    to = 0;
    while (!awready && to < 100) begin @(negedge aclk); to++; end
    check("aw_hs", 32'(awready), 1);
    @(negedge aclk);
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) begin wvalid = 0; repeat ($urandom_range(0, 2)) @(negedge aclk); end
      wid   = (mode == 1 && i == 0) ? (id ^ 4'h1) : id;
      wdata = wbuf[i];
      wstrb = sbuf[i];
      wlast = (mode == 2) ? (i == int'(len) - 1) : (mode == 3) ? 1'b0 : (i == int'(len));
      wvalid = 1;
      to = 0;
      while (!wready && to < 100) begin @(negedge aclk); to++; end
      check("w_hs", 32'(wready), 1);
      mdl_wr(beat_addr(addr, len, size, burst, i), wbuf[i], sbuf[i]);
      @(negedge aclk);
    end
    wvalid = 0; wlast = 0;
    to = 0;
    while (!bvalid && to < 100) begin @(negedge aclk); to++; end
    check("b_valid", 32'(bvalid), 1);
    repeat (bdly) begin
      @(negedge aclk);
      check("b_hold", {25'd0, bvalid, bid, bresp}, {25'd0, 1'b1, id, exp_resp});
    end
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(exp_resp));
    bready = 1;
    @(negedge aclk);
    bready = 0;
    check("b_drop", 32'(bvalid), 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rdly_max);
    bit          ill;
    int          to, idx, d;
    logic [31:0] a, exp_d;
    ill = illegal(len, size, burst);
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    to = 0;
    while (!arready && to < 100) begin @(negedge aclk); to++; end
    check("ar_hs", 32'(arready), 1);
    @(negedge aclk);
    arvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      a     = beat_addr(addr, len, size, burst, i);
      idx   = int'(a >> 2);
      exp_d = (idx < DEPTH) ? mdl[idx] : 32'd0;
      check("r_valid", 32'(rvalid), 1);
      check("rid", 32'(rid), 32'(id));
      check("rdata", rdata, exp_d);
      check("rresp", 32'(rresp), (ill || idx >= DEPTH) ? 32'd2 : 32'd0);
      check("rlast", 32'(rlast), 32'(i == int'(len)));
      last_rdata = rdata;
      d = $urandom_range(0, rdly_max);
      if (d > 0) begin
        rready = 0;
        repeat (d) @(negedge aclk);
        check("r_hold", rdata, exp_d);
      end
      rready = 1;
      @(negedge aclk);
    end
    rready = 0;
    check("r_drop", 32'(rvalid), 0);
  endtask

  task automatic fill_rand(input int n, input bit rand_strb);
    for (int i = 0; i < n; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = rand_strb ? 4'($urandom) : 4'hF;
    end
  endtask

  initial begin
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [7:0]  wl [4];
    wl[0] = 8'd1; wl[1] = 8'd3; wl[2] = 8'd7; wl[3] = 8'd15;

    // Reset values
    repeat (5) @(negedge aclk);
    check("rst_awready", 32'(awready), 1);
    check("rst_arready", 32'(arready), 1);
    check("rst_wready", 32'(wready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_bresp", 32'(bresp), 0);
    check("rst_rresp", 32'(rresp), 0);
    check("rst_ids", {24'd0, bid, rid}, 0);
    check("rst_rdata", rdata, 0);
    aresetn = 1;

    // Give words 0..127 known contents
    for (int k = 0; k < 8; k++) begin
      fill_rand(16, 0);
      axi_write(4'(k), 32'(k * 64), 8'd15, 3'd2, 2'b01, 0, 0, 0);
    end

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 0, 0, 0);
    axi_read(4'd7, 32'h10, 8'd3, 3'd2, 2'b01, 0);

    // WRAP read 0x38 -> 0x38,0x3C,0x30,0x34
    axi_read(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, 1);

    // Strobe merge with wvalid gaps and delayed bready
    wbuf[0] = 32'h0; sbuf[0] = 4'hF;
    axi_write(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 0, 0, 0);
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'b0101;
    axi_write(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 0, 1, 3);
    axi_read(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 0);
    check("strobe_merge", last_rdata, 32'h00AD00EF);

    // Error responses
    fill_rand(4, 0);
    axi_write(4'd3, 32'h40, 8'd3, 3'd2, 2'b01, 1, 0, 0);
    fill_rand(4, 0);
    axi_write(4'd3, 32'h40, 8'd3, 3'd2, 2'b01, 2, 0, 0);
    axi_read(4'd4, 32'(DEPTH * 4), 8'd1, 3'd2, 2'b01, 0);
    axi_read(4'd4, 32'h20, 8'd2, 3'd2, 2'b10, 0);
    fill_rand(3, 0);
    axi_write(4'd6, 32'h20, 8'd2, 3'd2, 2'b10, 0, 0, 0);
    axi_read(4'd4, 32'h20, 8'd1, 3'd2, 2'b11, 0);
    axi_read(4'd4, 32'h20, 8'd1, 3'd3, 2'b01, 0);
    fill_rand(1, 0);
    axi_write(4'd6, 32'(DEPTH * 4 + 8), 8'd0, 3'd2, 2'b01, 0, 0, 0);

    // Reset in the middle of a len=7 write
    @(negedge aclk);
    awid = 4'd9; awaddr = 32'h100; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1;
    check("mid_aw_hs", 32'(awready), 1);
    @(negedge aclk);
    awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      wid = 4'd9; wdata = $urandom; wstrb = 4'hF; wlast = 0; wvalid = 1;
      check("mid_w_hs", 32'(wready), 1);
      mdl_wr(32'h100 + 32'(4 * i), wdata, wstrb);
      @(negedge aclk);
    end
    wvalid = 0;
    aresetn = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
    repeat (3) @(negedge aclk);
    check("mid_bvalid", 32'(bvalid), 0);
    check("mid_wready", 32'(wready), 0);
    check("mid_awready", 32'(awready), 1);
    fill_rand(8, 0);
    axi_write(4'd9, 32'h100, 8'd7, 3'd2, 2'b01, 0, 1, 1);
    axi_read(4'd9, 32'h100, 8'd7, 3'd2, 2'b01, 1);

    // Overlapping write and read bursts on disjoint words
    fill_rand(16, 1);
    fork
      axi_write(4'd10, 32'h180, 8'd15, 3'd2, 2'b01, 0, 1, 2);
      axi_read(4'd11, 32'h000, 8'd15, 3'd2, 2'b01, 2);
    join
    axi_read(4'd12, 32'h180, 8'd15, 3'd2, 2'b01, 0);

    // Random traffic in the first 512 bytes
    for (int n = 0; n < 40; n++) begin
      size  = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 2));
      len   = (burst == 2'b10) ? wl[$urandom_range(0, 3)] : 8'($urandom_range(0, 15));
      addr  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) burst = 2'b11; else size = 3'd3;
      end
      if ($urandom_range(0, 1) == 0) begin
        fill_rand(int'(len) + 1, 1);
        axi_write(4'($urandom), addr, len, size, burst,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
                  1'($urandom), int'($urandom_range(0, 3)));
      end else begin
        axi_read(4'($urandom), addr, len, size, burst, 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
